compare_scan: RTL and testbench

Self-test sequencer for the 2-bit magnitude comparator. On `start` it walks all 16 (a, b) operand pairs through one comparator instance and holds each operand pair and its result on the LEDs for a dwell period. It tallies greater/equal/less outcomes and flags any result that disagrees with an internally computed expected value. It sits between the board keys and the comparator instance in the lab top level, replacing manual switch stimulus.

---
 rtl/compare_scan_pkg.sv | 32 +++
 rtl/compare_scan_if.sv | 32 +++
 rtl/compare_scan_dwell_tmr.sv | 30 +++
 rtl/compare_scan.sv | 141 ++++++++++++++
 tb/tb_compare_scan.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/compare_scan_pkg.sv
// compare_scan shared types: FSM states, result bit positions,
// scan size, expected tallies and the reference relation of a pair.
package compare_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DWELL,
    ST_DONE
  } state_t;

  localparam int RES_GT    = 2;
  localparam int RES_EQ    = 1;
  localparam int RES_LT    = 0;
  localparam int NUM_PAIRS = 16;
  localparam int CNT_W     = 5;

  localparam logic [CNT_W-1:0] EXP_GT = 5'd6;
  localparam logic [CNT_W-1:0] EXP_EQ = 5'd4;
  localparam logic [CNT_W-1:0] EXP_LT = 5'd6;

  // idx[3:2] is b, idx[1:0] is a
  function automatic logic [2:0] exp_res(input logic [3:0] idx);
    logic [1:0] a;
    logic [1:0] b;
    a = idx[1:0];
    b = idx[3:2];
    exp_res = {a > b, a == b, a < b};
  endfunction

endpackage

// File: rtl/compare_scan_if.sv
// compare_scan bus: keys/step controls, comparator operands and result,
// LED and status outputs. master = lab top side, slave = sequencer.
interface compare_scan_if;
  import compare_pkg::*;

  logic             start;
  logic             step_mode;
  logic             step;
  logic [1:0]       cmp_a;
  logic [1:0]       cmp_b;
  logic [2:0]       cmp_res;
  logic [2:0]       led;
  logic             busy;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] gt_cnt;
  logic [CNT_W-1:0] eq_cnt;
  logic [CNT_W-1:0] lt_cnt;

  modport master (
    output start, step_mode, step, cmp_res,
    input  cmp_a, cmp_b, led, busy, done, err,
    input  gt_cnt, eq_cnt, lt_cnt
  );

  modport slave (
    input  start, step_mode, step, cmp_res,
    output cmp_a, cmp_b, led, busy, done, err,
    output gt_cnt, eq_cnt, lt_cnt
  );

endinterface

// File: rtl/compare_scan_dwell_tmr.sv
// Loadable down-counter timing both the SETTLE and DWELL phases.
// Ports: clk, rst_n, i_load/i_val (reload), i_en (count), o_expire.
module compare_dwell_tmr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  input  logic         i_en,
  output logic         o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_en && r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // last counted cycle of the phase; gating with i_en freezes the
  // count while DWELL runs in step mode
  assign o_expire = i_en && (r_cnt <= W'(1));

endmodule

// File: rtl/compare_scan.sv
// Self-test sequencer walking all 16 (a,b) pairs through a comparator.
// Ports: clk, rst_n, bus (compare_scan_if.slave).
module compare_scan
  import compare_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int DWELL  = 12_000_000
) (
  input  logic           clk,
  input  logic           rst_n,
  compare_scan_if.slave  bus
);

  localparam int MAXC = (DWELL > SETTLE) ? DWELL : SETTLE;
  localparam int TW   = $clog2(MAXC + 1);

  state_t           r_state;
  logic [3:0]       r_idx;
  logic [2:0]       r_led;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [CNT_W-1:0] r_gt;
  logic [CNT_W-1:0] r_eq;
  logic [CNT_W-1:0] r_lt;

  logic          w_load;
  logic [TW-1:0] w_val;
  logic          w_en;
  logic          w_expire;
  logic          w_adv;
  logic          w_last;

  assign w_last = (r_idx == 4'(NUM_PAIRS - 1));
  assign w_adv  = (r_state == ST_DWELL) &&
                  (bus.step_mode ? bus.step : w_expire);

  always_comb begin
    w_load = 1'b0;
    w_val  = '0;
    w_en   = 1'b0;
    unique case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_val  = TW'(SETTLE);
        end
      end
      ST_SETTLE: w_en = 1'b1;
      ST_SAMPLE: begin
        w_load = 1'b1;
        w_val  = TW'(DWELL);
      end
      ST_DWELL: begin
        w_en = !bus.step_mode;
        if (w_adv && !w_last) begin
          w_load = 1'b1;
          w_val  = TW'(SETTLE);
        end
      end
      default: ;
    endcase
  end

  compare_dwell_tmr #(
    .W (TW)
  ) u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_load),
    .i_val    (w_val),
    .i_en     (w_en),
    .o_expire (w_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_led   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_gt    <= '0;
      r_eq    <= '0;
      r_lt    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state <= ST_SETTLE;
            r_idx   <= '0;
            r_led   <= '0;
            r_err   <= 1'b0;
            r_gt    <= '0;
            r_eq    <= '0;
            r_lt    <= '0;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        ST_SETTLE: begin
          if (w_expire) r_state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          r_led <= bus.cmp_res;
          r_gt  <= r_gt + CNT_W'(bus.cmp_res[RES_GT]);
          r_eq  <= r_eq + CNT_W'(bus.cmp_res[RES_EQ]);
          r_lt  <= r_lt + CNT_W'(bus.cmp_res[RES_LT]);
          // full-vector compare also catches non-one-hot results
          if (bus.cmp_res != exp_res(r_idx)) r_err <= 1'b1;
          r_state <= ST_DWELL;
        end
        ST_DWELL: begin
          if (w_adv) begin
            if (w_last) begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= ST_SETTLE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cmp_a  = r_idx[1:0];
  assign bus.cmp_b  = r_idx[3:2];
  assign bus.led    = r_led;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.err    = r_err;
  assign bus.gt_cnt = r_gt;
  assign bus.eq_cnt = r_eq;
  assign bus.lt_cnt = r_lt;

endmodule

// File: tb/tb_compare_scan.sv
// Bench for compare_scan: timed scoreboard of full scans, fault
// injection, step mode, ignored start and mid-scan reset.
module tb_compare_scan;

  localparam int SET = 2;
  localparam int DWL = 4;
  localparam int P   = SET + 1 + DWL;
  localparam int NP  = 16;

  logic clk;
  logic rst_n;
  bit   fault;
  int   cyc;
  int   n_chk;
  int   n_fail;

  compare_scan_if bus();

  compare_scan #(
    .SETTLE (SET),
    .DWELL  (DWL)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // comparator under test; fault forces a==b for (b=3,a=0)
  function automatic logic [2:0] dev(input int a, input int b,
                                     input bit f);
    if (f && b == 3 && a == 0) return 3'b010;
    return {a > b, a == b, a < b};
  endfunction

  assign bus.cmp_res = dev(int'(bus.cmp_a), int'(bus.cmp_b), fault);

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic chk_reset();
    chk("rst_a", 32'(bus.cmp_a), 0);
    chk("rst_b", 32'(bus.cmp_b), 0);
    chk("rst_led", 32'(bus.led), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_gt", 32'(bus.gt_cnt), 0);
    chk("rst_eq", 32'(bus.eq_cnt), 0);
    chk("rst_lt", 32'(bus.lt_cnt), 0);
  endtask

  // Called at a negedge; start is sampled at the next edge. Then
  // every cycle is compared against a timeline computed from the
  // pair period: pair i occupies offsets [i*P, i*P+P-1] and its
  // result is visible from offset i*P+SET+1.
  task automatic run_scan(input int inj, input int stop_off);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int off = 0; off <= NP * P + 3; off++) begin
      int pr, ns, g, e, l, er;
      logic [2:0] led;
      if (off == stop_off) return;
      pr = (off < NP * P) ? off / P : NP - 1;
      ns = 0;
      for (int i = 0; i < NP; i++)
        if (i * P + SET + 1 <= off) ns++;
      g = 0; e = 0; l = 0; er = 0;
      led = 3'b000;
      for (int i = 0; i < ns; i++) begin
        led = dev(i % 4, i / 4, fault);
        g += led[2];
        e += led[1];
        l += led[0];
        if (led != dev(i % 4, i / 4, 1'b0)) er = 1;
      end
      chk("op_a", 32'(bus.cmp_a), pr % 4);
      chk("op_b", 32'(bus.cmp_b), pr / 4);
      chk("led", 32'(bus.led), 32'(led));
      chk("busy", 32'(bus.busy), (off < NP * P) ? 1 : 0);
      chk("done", 32'(bus.done), (off < NP * P) ? 0 : 1);
      chk("err", 32'(bus.err), er);
      chk("gt", 32'(bus.gt_cnt), g);
      chk("eq", 32'(bus.eq_cnt), e);
      chk("lt", 32'(bus.lt_cnt), l);
      bus.start = (off == inj);
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    fault = 1'b0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.step = 1'b0;
    bus.step_mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_reset();

    // start sampled at edge 10
    while (cyc < 9) @(negedge clk);
    run_scan(-1, -1);
    chk("final_gt", 32'(bus.gt_cnt), 6);
    chk("final_eq", 32'(bus.eq_cnt), 4);
    chk("final_lt", 32'(bus.lt_cnt), 6);

    // start inside the scan must not disturb the timeline
    run_scan(30, -1);

    // faulty comparator
    fault = 1'b1;
    run_scan(-1, -1);
    chk("flt_err", 32'(bus.err), 1);
    chk("flt_eq", 32'(bus.eq_cnt), 5);
    chk("flt_lt", 32'(bus.lt_cnt), 5);
    fault = 1'b0;

    // step mode: hold in DWELL of pair 0, then step through
    bus.step_mode = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (SET + 1) @(negedge clk);
    for (int t = 0; t < 100; t++) begin
      chk("hold_a", 32'(bus.cmp_a), 0);
      chk("hold_b", 32'(bus.cmp_b), 0);
      chk("hold_busy", 32'(bus.busy), 1);
      @(negedge clk);
    end
    for (int i = 0; i < NP; i++) begin
      chk("stp_a", 32'(bus.cmp_a), i % 4);
      chk("stp_b", 32'(bus.cmp_b), i / 4);
      chk("stp_led", 32'(bus.led), 32'(dev(i % 4, i / 4, 1'b0)));
      chk("stp_done", 32'(bus.done), 0);
      bus.step = 1'b1;
      @(negedge clk);
      bus.step = 1'b0;
      if (i < NP - 1) begin
        repeat (SET + 1) @(negedge clk);
        @(negedge clk);
      end
    end
    chk("stp_fdone", 32'(bus.done), 1);
    chk("stp_gt", 32'(bus.gt_cnt), 6);
    chk("stp_eq", 32'(bus.eq_cnt), 4);
    chk("stp_lt", 32'(bus.lt_cnt), 6);
    chk("stp_err", 32'(bus.err), 0);
    bus.step_mode = 1'b0;

    // reset during pair 9, then a clean rescan
    @(negedge clk);
    run_scan(-1, 9 * P + 4);
    chk("mid_b", 32'(bus.cmp_b), 2);
    chk("mid_a", 32'(bus.cmp_a), 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset();
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 0);
    run_scan(-1, -1);
    chk("re_gt", 32'(bus.gt_cnt), 6);
    chk("re_eq", 32'(bus.eq_cnt), 4);
    chk("re_lt", 32'(bus.lt_cnt), 6);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
